// File: rtl/config_tree_pkg.sv
// Shared types and width helpers for the pipelined configurable adder tree.
package config_tree_pkg;

  typedef enum logic {MODE_FULL, MODE_HALVED} prec_mode_e;

  function automatic int unsigned tree_out_width(input int unsigned p, input int unsigned n);
    return p + 2 * $clog2(n);
  endfunction

endpackage

// File: rtl/config_adder.sv
// Two-operand adder that either sums full W-bit words or two packed W/2-bit lanes.
module config_adder
  import config_tree_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         mode_i,
  output logic [W+1:0] sum_o
);

  localparam int unsigned H = W / 2;

  logic [W+1:0] w_full;
  logic [H:0]   w_hi;
  logic [H:0]   w_lo;

  assign w_full = {{2{a_i[W-1]}}, a_i} + {{2{b_i[W-1]}}, b_i};

  // Each lane grows by one bit, so the packed result still totals W+2 bits.
  assign w_lo = {a_i[H-1], a_i[H-1:0]} + {b_i[H-1], b_i[H-1:0]};
  assign w_hi = {a_i[W-1], a_i[W-1:H]} + {b_i[W-1], b_i[W-1:H]};

  assign sum_o = (prec_mode_e'(mode_i) == MODE_HALVED) ? {w_hi, w_lo} : w_full;

endmodule

// File: rtl/config_tree_stage.sv
// One reduction layer of the tree: pairwise configurable adders followed by a
// valid/ready register stage carrying the precision mode with the data.
module config_tree_stage
  import config_tree_pkg::*;
#(
  parameter int unsigned INPUTS_AMOUNT = 8,
  parameter int unsigned P             = 8
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [INPUTS_AMOUNT*P-1:0]           in_data_i,
  input  logic                                 in_halved_i,
  input  logic                                 in_valid_i,
  output logic                                 in_ready_o,
  output logic [(INPUTS_AMOUNT/2)*(P+2)-1:0]   out_data_o,
  output logic                                 out_halved_o,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i
);

  localparam int unsigned Pairs = INPUTS_AMOUNT / 2;
  localparam int unsigned OutW  = P + 2;

  logic [Pairs*OutW-1:0] w_sum;
  logic                  w_load;
  logic [Pairs*OutW-1:0] r_data;
  prec_mode_e            r_mode;
  logic                  r_valid;

  for (genvar i = 0; i < Pairs; i++) begin : g_pair
    config_adder #(
      .W(P)
    ) u_add (
      .a_i   (in_data_i[(2*i)*P +: P]),
      .b_i   (in_data_i[(2*i+1)*P +: P]),
      .mode_i(in_halved_i),
      .sum_o (w_sum[i*OutW +: OutW])
    );
  end

  // Loading while full and draining lets a new beat replace the old one with no bubble.
  assign w_load     = !r_valid || out_ready_i;
  assign in_ready_o = w_load;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_mode  <= MODE_FULL;
    end else if (w_load) begin
      r_valid <= in_valid_i;
      if (in_valid_i) begin
        r_data <= w_sum;
        r_mode <= prec_mode_e'(in_halved_i);
      end
    end
  end

  assign out_data_o   = r_data;
  assign out_halved_o = (r_mode == MODE_HALVED);
  assign out_valid_o  = r_valid;

endmodule

// File: rtl/config_pipelined_tree_adder.sv
// Streaming log2(N)-layer reduction tree; one register stage per layer with
// valid/ready back-pressure and a per-beat full/halved precision mode.
module config_pipelined_tree_adder
  import config_tree_pkg::*;
#(
  parameter int unsigned INPUTS_AMOUNT = 8,
  parameter int unsigned P             = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [INPUTS_AMOUNT*P-1:0]                 in_data_i,
  input  logic                                       in_halved_i,
  input  logic                                       in_valid_i,
  output logic                                       in_ready_o,
  output logic [tree_out_width(P, INPUTS_AMOUNT)-1:0] out_sum_o,
  output logic                                       out_halved_o,
  output logic                                       out_valid_o,
  input  logic                                       out_ready_i
);

  localparam int unsigned LAYERS = $clog2(INPUTS_AMOUNT);

  // w_ready[k] is the ready seen by stage k from downstream; w_ready[0] faces the input.
  logic [LAYERS:0] w_ready;

  assign w_ready[LAYERS] = out_ready_i;
  assign in_ready_o      = w_ready[0];

  for (genvar k = 1; k <= LAYERS; k++) begin : g_layer
    localparam int unsigned NumIn   = INPUTS_AMOUNT >> (k - 1);
    localparam int unsigned WidthIn = P + 2 * (k - 1);
    localparam int unsigned OutBusW = (NumIn / 2) * (WidthIn + 2);

    logic [NumIn*WidthIn-1:0] w_in_data;
    logic                     w_in_halved;
    logic                     w_in_valid;
    logic [OutBusW-1:0]       w_out_data;
    logic                     w_out_halved;
    logic                     w_out_valid;

    if (k == 1) begin : g_first
      assign w_in_data   = in_data_i;
      assign w_in_halved = in_halved_i;
      assign w_in_valid  = in_valid_i;
    end else begin : g_chain
      assign w_in_data   = g_layer[k-1].w_out_data;
      assign w_in_halved = g_layer[k-1].w_out_halved;
      assign w_in_valid  = g_layer[k-1].w_out_valid;
    end

    config_tree_stage #(
      .INPUTS_AMOUNT(NumIn),
      .P            (WidthIn)
    ) u_stage (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .in_data_i   (w_in_data),
      .in_halved_i (w_in_halved),
      .in_valid_i  (w_in_valid),
      .in_ready_o  (w_ready[k-1]),
      .out_data_o  (w_out_data),
      .out_halved_o(w_out_halved),
      .out_valid_o (w_out_valid),
      .out_ready_i (w_ready[k])
    );
  end

  assign out_sum_o    = g_layer[LAYERS].w_out_data;
  assign out_halved_o = g_layer[LAYERS].w_out_halved;
  assign out_valid_o  = g_layer[LAYERS].w_out_valid;

endmodule
